gc_refresh_scheduler: RTL and testbench

Multi-bank refresh scheduler for the gain-cell DRAM array.
- Per bank, a "fresh" bitmap tracks which rows have been refreshed or written since the current refresh round started.
- A sweep pointer walks every row, and a user read of a stale row is refreshed ahead of the pointer.
- New relative to the single-bank tracker: parametrised depth and bank count, skip-if-fresh, valid/ready to the array, and an internal retention timer that launches rounds and flags overruns.
- Sits between the user-port arbiter and the per-bank array controllers.

---
 rtl/gc_refresh_pkg.sv | 17 +
 rtl/gc_refresh_bank.sv | 83 ++++++++
 rtl/gc_refresh_scheduler.sv | 68 ++++++
 tb/tb_gc_refresh_scheduler.sv | 569 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_refresh_pkg.sv
// Shared types and defaults for the gain-cell refresh scheduler.
package gc_refresh_pkg;

    typedef enum logic {
        SWEEP,
        DONE
    } state_e;

    localparam int DEF_ROWS      = 128;
    localparam int DEF_BANKS     = 2;
    localparam int DEF_RETENTION = 4096;

    function automatic int addr_lsb(input int bank, input int addr_w);
        return bank * addr_w;
    endfunction

endpackage

// File: rtl/gc_refresh_bank.sv
// One bank: fresh bitmap, sweep pointer, read-priority refresh and
// the SWEEP/DONE round FSM.
module gc_refresh_bank
    import gc_refresh_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int ADDR_W     = $clog2(ROWS),
    parameter bit SKIP_FRESH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              round_start_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              ref_ready_i,
    output logic              ref_valid_o,
    output logic [ADDR_W-1:0] ref_addr_o,
    output logic              ind_user_o,
    output logic              done_o,
    output logic              overrun_o
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    state_e            state_q;
    logic [ROWS-1:0]   fresh_q, fresh_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, overrun_q;
    logic              sweep, prio, ptr_fresh;
    logic              accept, advance, last;

    assign sweep     = (state_q == SWEEP);
    assign ptr_fresh = fresh_q[ptr_q];
    // A stale user read jumps ahead of the sweep pointer.
    assign prio      = sweep & rd_en_i & ~fresh_q[rd_addr_i];

    assign ref_valid_o = sweep & (prio | ~(SKIP_FRESH & ptr_fresh));
    assign ref_addr_o  = prio ? rd_addr_i : ptr_q;
    assign ind_user_o  = fresh_q[rd_addr_i];
    assign done_o      = done_q;
    assign overrun_o   = overrun_q;

    assign accept  = ref_valid_o & ref_ready_i;
    assign advance = sweep & ~prio
                   & (accept | (SKIP_FRESH & ptr_fresh));
    assign last    = advance & (ptr_q == LAST_ROW);

    always_comb begin
        fresh_d = fresh_q;
        ptr_d   = ptr_q;
        if (round_start_i) begin
            fresh_d = '0;
            ptr_d   = '0;
        end else if (sweep) begin
            if (accept)  fresh_d[ref_addr_o] = 1'b1;
            if (wr_en_i) fresh_d[wr_addr_i]  = 1'b1;
            if (advance && !last) ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DONE;
            fresh_q   <= '0;
            ptr_q     <= '0;
            done_q    <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            fresh_q <= fresh_d;
            ptr_q   <= ptr_d;
            done_q  <= ~sweep;
            if (round_start_i) begin
                state_q <= SWEEP;
                if (sweep) overrun_q <= 1'b1;
            end else if (last) begin
                state_q <= DONE;
            end
        end
    end

endmodule

// File: rtl/gc_refresh_scheduler.sv
// Multi-bank refresh scheduler: per-bank sweepers sharing one
// retention timer that launches refresh rounds.
module gc_refresh_scheduler
    import gc_refresh_pkg::*;
#(
    parameter int ROWS             = DEF_ROWS,
    parameter int ADDR_W           = $clog2(ROWS),
    parameter int BANKS            = DEF_BANKS,
    parameter int RETENTION_CYCLES = DEF_RETENTION,
    parameter bit SKIP_FRESH       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [BANKS-1:0]        wr_en_i,
    input  logic [BANKS*ADDR_W-1:0] wr_addr_i,
    input  logic [BANKS-1:0]        rd_en_i,
    input  logic [BANKS*ADDR_W-1:0] rd_addr_i,
    input  logic [BANKS-1:0]        ref_ready_i,
    output logic [BANKS-1:0]        ref_valid_o,
    output logic [BANKS*ADDR_W-1:0] ref_addr_o,
    output logic [BANKS-1:0]        ind_user_o,
    output logic [BANKS-1:0]        done_o,
    output logic [BANKS-1:0]        overrun_o
);

    localparam int TMR_W = $clog2(RETENTION_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST =
        TMR_W'(RETENTION_CYCLES - 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             tc, round_start;

    assign tc          = (timer_q == TMR_LAST);
    // start and terminal count merge into one round start.
    assign round_start = start_i | tc;
    assign timer_d     = round_start ? '0 : timer_q + TMR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        localparam int LSB = addr_lsb(b, ADDR_W);

        gc_refresh_bank #(
            .ROWS      (ROWS),
            .ADDR_W    (ADDR_W),
            .SKIP_FRESH(SKIP_FRESH)
        ) u_bank (
            .clk          (clk),
            .rst          (rst),
            .round_start_i(round_start),
            .wr_en_i      (wr_en_i[b]),
            .wr_addr_i    (wr_addr_i[LSB +: ADDR_W]),
            .rd_en_i      (rd_en_i[b]),
            .rd_addr_i    (rd_addr_i[LSB +: ADDR_W]),
            .ref_ready_i  (ref_ready_i[b]),
            .ref_valid_o  (ref_valid_o[b]),
            .ref_addr_o   (ref_addr_o[LSB +: ADDR_W]),
            .ind_user_o   (ind_user_o[b]),
            .done_o       (done_o[b]),
            .overrun_o    (overrun_o[b])
        );
    end

endmodule

// File: tb/tb_gc_refresh_scheduler.sv
// Bench for gc_refresh_scheduler: directed scenarios plus random
// traffic against a row-level reference model.
module tb_gc_refresh_scheduler;

    localparam int ROWS = 128;
    localparam int AW   = 7;
    localparam int NB   = 2;
    localparam int RET  = 300;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             start;
    logic [NB-1:0]    wr_en, rd_en, ready;
    logic [NB*AW-1:0] wr_addr, rd_addr;
    logic [NB-1:0]    ref_valid, ind_user, done, overrun;
    logic [NB*AW-1:0] ref_addr;

    gc_refresh_scheduler #(
        .ROWS(ROWS), .ADDR_W(AW), .BANKS(NB),
        .RETENTION_CYCLES(RET), .SKIP_FRESH(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .ref_ready_i(ready), .ref_valid_o(ref_valid),
        .ref_addr_o(ref_addr), .ind_user_o(ind_user),
        .done_o(done), .overrun_o(overrun)
    );

    logic       start_b, wr_en_b, rd_en_b, ready_b;
    logic [3:0] wr_addr_b, rd_addr_b, addr_b;
    logic       valid_b, ind_b, done_b, ovr_b;

    gc_refresh_scheduler #(
        .ROWS(16), .ADDR_W(4), .BANKS(1),
        .RETENTION_CYCLES(64), .SKIP_FRESH(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b),
        .wr_en_i(wr_en_b), .wr_addr_i(wr_addr_b),
        .rd_en_i(rd_en_b), .rd_addr_i(rd_addr_b),
        .ref_ready_i(ready_b), .ref_valid_o(valid_b),
        .ref_addr_o(addr_b), .ind_user_o(ind_b),
        .done_o(done_b), .overrun_o(ovr_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one bit per row, pointer as an integer.
    bit [ROWS-1:0] m_fresh[NB];
    int            m_ptr[NB];
    bit            m_sweep[NB], m_done[NB], m_ovr[NB];
    int            m_tmr;

    function automatic int raddr(int b);
        return int'(rd_addr[b*AW +: AW]);
    endfunction

    function automatic int oaddr(int b);
        return int'(ref_addr[b*AW +: AW]);
    endfunction

    function automatic bit m_prio(int b);
        return m_sweep[b] && rd_en[b] && !m_fresh[b][raddr(b)];
    endfunction

    function automatic bit m_valid(int b);
        return m_sweep[b] && (m_prio(b) || !m_fresh[b][m_ptr[b]]);
    endfunction

    function automatic int m_addr(int b);
        return m_prio(b) ? raddr(b) : m_ptr[b];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_fresh[b] = '0;
            m_ptr[b]   = 0;
            m_sweep[b] = 0;
            m_done[b]  = 1;
            m_ovr[b]   = 0;
        end
        m_tmr = 0;
    endtask

    task automatic model_tick();
        bit rs, sw, pr, v, pf, acc;
        int a;
        rs    = start || (m_tmr == RET - 1);
        m_tmr = rs ? 0 : m_tmr + 1;
        for (int b = 0; b < NB; b++) begin
            sw  = m_sweep[b];
            pr  = m_prio(b);
            v   = m_valid(b);
            a   = m_addr(b);
            pf  = m_fresh[b][m_ptr[b]];
            acc = v && ready[b];
            m_done[b] = !sw;
            if (rs) begin
                if (sw) m_ovr[b] = 1;
                m_fresh[b] = '0;
                m_ptr[b]   = 0;
                m_sweep[b] = 1;
            end else if (sw) begin
                if (acc) m_fresh[b][a] = 1;
                if (wr_en[b]) m_fresh[b][int'(wr_addr[b*AW +: AW])] = 1;
                if (!pr && (pf || acc)) begin
                    if (m_ptr[b] == ROWS - 1) m_sweep[b] = 0;
                    else m_ptr[b]++;
                end
            end
        end
    endtask

    task automatic cyc();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(int b, bit en, int a);
        rd_en[b] = en;
        rd_addr[b*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(int b, bit en, int a);
        wr_en[b] = en;
        wr_addr[b*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        start = 0; wr_en = '0; rd_en = '0;
        wr_addr = '0; rd_addr = '0; ready = '1;
        start_b = 0; wr_en_b = 0; rd_en_b = 0;
        wr_addr_b = '0; rd_addr_b = '0; ready_b = 1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_rd(0, 1, i * 37);
            set_rd(1, 1, i * 11 + 3);
            #1;
            checks++;
            if (done !== 2'b11) begin
                errors++;
                $display("FAIL reset done got %b want 11", done);
            end
            checks++;
            if (ref_valid !== 2'b00) begin
                errors++;
                $display("FAIL reset valid got %b want 00", ref_valid);
            end
            checks++;
            if (overrun !== 2'b00) begin
                errors++;
                $display("FAIL reset overrun got %b want 00", overrun);
            end
            checks++;
            if (ind_user !== 2'b00) begin
                errors++;
                $display("FAIL reset ind got %b want 00", ind_user);
            end
            cyc();
        end
    endtask

    task automatic test_full_sweep();
        int a;
        idle();
        start = 1;
        #1; cyc();
        start = 0;
        for (int i = 0; i < ROWS; i++) begin
            #1;
            for (int b = 0; b < NB; b++) begin
                checks++;
                if (ref_valid[b] !== 1'b1 || oaddr(b) != i) begin
                    errors++;
                    $display("FAIL sweep b%0d got v%b a%0d want v1 a%0d",
                             b, ref_valid[b], oaddr(b), i);
                end
            end
            cyc();
        end
        #1;
        checks++;
        if (done !== 2'b00 || ref_valid !== 2'b00) begin
            errors++;
            $display("FAIL sweep_end1 got d%b v%b want d00 v00",
                     done, ref_valid);
        end
        cyc();
        #1;
        checks++;
        if (done !== 2'b11) begin
            errors++;
            $display("FAIL sweep_end2 done got %b want 11", done);
        end
        cyc();
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(ROWS - 1);
            set_rd(0, 0, a);
            set_rd(1, 1, ROWS - 1 - a);
            #1;
            checks++;
            if (ind_user !== 2'b11) begin
                errors++;
                $display("FAIL sweep_ind row %0d got %b want 11",
                         a, ind_user);
            end
            cyc();
        end
    endtask

    task automatic test_read_prio();
        int n, cnt;
        bit saw;
        idle();
        start = 1;
        #1; cyc();
        start = 0;
        repeat (10) cyc();
        set_rd(0, 1, 90);
        #1;
        checks++;
        if (ref_valid[0] !== 1'b1 || oaddr(0) != 90) begin
            errors++;
            $display("FAIL prio got v%b a%0d want v1 a90",
                     ref_valid[0], oaddr(0));
        end
        checks++;
        if (ind_user[0] !== 1'b0) begin
            errors++;
            $display("FAIL prio_ind got %b want 0", ind_user[0]);
        end
        cyc();
        set_rd(0, 0, 90);
        #1;
        checks++;
        if (ref_valid[0] !== 1'b1 || oaddr(0) != 10) begin
            errors++;
            $display("FAIL prio_hold got a%0d want a10", oaddr(0));
        end
        checks++;
        if (ind_user[0] !== 1'b1) begin
            errors++;
            $display("FAIL prio_fresh got %b want 1", ind_user[0]);
        end
        n = 0; cnt = 0; saw = 0;
        while (done[0] !== 1'b1 && n < 300) begin
            #1;
            if (ref_valid[0]) begin
                cnt++;
                if (oaddr(0) == 90) saw = 1;
            end
            cyc();
            n++;
        end
        checks++;
        if (cnt != 117 || saw || n >= 300) begin
            errors++;
            $display("FAIL prio_skip got cnt%0d saw90=%0d n%0d want 117 0",
                     cnt, saw, n);
        end
    endtask

    task automatic test_writes();
        int n, cnt;
        bit bad;
        idle();
        start = 1;
        #1; cyc();
        start = 0;
        n = 0; cnt = 0; bad = 0;
        while ((n < 2 || done[0] !== 1'b1) && n < 300) begin
            if (n < 3) set_wr(0, 1, 5 + n);
            else       set_wr(0, 0, 0);
            #1;
            if (ref_valid[0]) begin
                cnt++;
                if (oaddr(0) >= 5 && oaddr(0) <= 7) bad = 1;
            end
            cyc();
            n++;
        end
        checks++;
        if (cnt != 125 || bad || n >= 300) begin
            errors++;
            $display("FAIL writes got cnt%0d bad%0d n%0d want 125 0",
                     cnt, bad, n);
        end
    endtask

    task automatic test_stall();
        int n;
        idle();
        start = 1;
        #1; cyc();
        start = 0;
        repeat (20) cyc();
        for (int j = 0; j < 4; j++) begin
            ready = 2'b10;
            #1;
            checks++;
            if (ref_valid[0] !== 1'b1 || oaddr(0) != 20) begin
                errors++;
                $display("FAIL stall b0 got v%b a%0d want v1 a20",
                         ref_valid[0], oaddr(0));
            end
            checks++;
            if (oaddr(1) != 20 + j) begin
                errors++;
                $display("FAIL stall b1 got a%0d want a%0d",
                         oaddr(1), 20 + j);
            end
            cyc();
        end
        ready = 2'b11;
        #1;
        checks++;
        if (oaddr(0) != 20) begin
            errors++;
            $display("FAIL stall_acc got a%0d want a20", oaddr(0));
        end
        cyc();
        #1;
        checks++;
        if (ref_valid[0] !== 1'b1 || oaddr(0) != 21) begin
            errors++;
            $display("FAIL stall_resume got a%0d want a21", oaddr(0));
        end
        n = 0;
        while (done !== 2'b11 && n < 300) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL stall_done timeout got %b want 11", done);
        end
    endtask

    task automatic test_noskip();
        int exp_q[$];
        int idx, n;
        idle();
        exp_q = {0, 1, 2, 10};
        for (int r = 3; r < 16; r++) exp_q.push_back(r);
        start_b = 1;
        #1; cyc();
        start_b = 0;
        idx = 0; n = 0;
        while (idx < 17 && n < 40) begin
            rd_en_b   = (n == 3);
            rd_addr_b = 4'd10;
            #1;
            if (valid_b) begin
                checks++;
                if (int'(addr_b) != exp_q[idx]) begin
                    errors++;
                    $display("FAIL noskip #%0d got a%0d want a%0d",
                             idx, addr_b, exp_q[idx]);
                end
                idx++;
            end
            cyc();
            n++;
        end
        rd_en_b = 0;
        checks++;
        if (idx != 17) begin
            errors++;
            $display("FAIL noskip_count got %0d want 17", idx);
        end
        #1;
        checks++;
        if (valid_b !== 1'b0 || ind_b !== 1'b1) begin
            errors++;
            $display("FAIL noskip_end got v%b i%b want v0 i1",
                     valid_b, ind_b);
        end
        cyc();
    endtask

    task automatic test_overrun();
        int n;
        do_reset();
        start = 1;
        #1; cyc();
        start = 0;
        n = 0;
        while (m_tmr != RET - 1 && n < 400) begin
            ready[0] = ($urandom % 4 == 0);
            ready[1] = 1'b1;
            #1;
            checks++;
            if (ref_valid[0] !== m_valid(0)) begin
                errors++;
                $display("FAIL ovr_valid got %b want %b",
                         ref_valid[0], m_valid(0));
            end
            cyc();
            n++;
        end
        ready = 2'b11;
        #1;
        checks++;
        if (done !== 2'b10 || overrun !== 2'b00 || n >= 400) begin
            errors++;
            $display("FAIL ovr_pre got d%b o%b want d10 o00",
                     done, overrun);
        end
        cyc();
        #1;
        checks++;
        if (overrun !== 2'b01) begin
            errors++;
            $display("FAIL ovr_flag got %b want 01", overrun);
        end
        checks++;
        if (ref_valid !== 2'b11 || oaddr(0) != 0 || oaddr(1) != 0) begin
            errors++;
            $display("FAIL ovr_restart got v%b a%0d/%0d want 11 0/0",
                     ref_valid, oaddr(0), oaddr(1));
        end
        cyc();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            start = ($urandom % 150 == 0);
            for (int b = 0; b < NB; b++) begin
                set_rd(b, $urandom % 3 == 0, $urandom_range(ROWS - 1));
                set_wr(b, $urandom % 4 == 0, $urandom_range(ROWS - 1));
                ready[b] = ($urandom % 4 != 0);
            end
            #1;
            for (int b = 0; b < NB; b++) begin
                checks++;
                if (ref_valid[b] !== m_valid(b)) begin
                    errors++;
                    $display("FAIL rnd_valid n%0d b%0d got %b want %b",
                             n, b, ref_valid[b], m_valid(b));
                end
                if (m_valid(b)) begin
                    checks++;
                    if (oaddr(b) != m_addr(b)) begin
                        errors++;
                        $display("FAIL rnd_addr n%0d b%0d got %0d want %0d",
                                 n, b, oaddr(b), m_addr(b));
                    end
                end
                checks++;
                if (ind_user[b] !== m_fresh[b][raddr(b)]) begin
                    errors++;
                    $display("FAIL rnd_ind n%0d b%0d got %b want %b",
                             n, b, ind_user[b], m_fresh[b][raddr(b)]);
                end
                checks++;
                if (done[b] !== m_done[b]) begin
                    errors++;
                    $display("FAIL rnd_done n%0d b%0d got %b want %b",
                             n, b, done[b], m_done[b]);
                end
                checks++;
                if (overrun[b] !== m_ovr[b]) begin
                    errors++;
                    $display("FAIL rnd_ovr n%0d b%0d got %b want %b",
                             n, b, overrun[b], m_ovr[b]);
                end
            end
            cyc();
        end
        idle();
    endtask

    task automatic test_rst_mid();
        int n, w;
        idle();
        start = 1;
        #1; cyc();
        start = 0;
        repeat (64) cyc();
        #1;
        checks++;
        if (oaddr(0) != 64) begin
            errors++;
            $display("FAIL rstmid_ptr got a%0d want a64", oaddr(0));
        end
        rst = 1;
        #1;
        checks++;
        if (done !== 2'b11 || ref_valid !== 2'b00 || overrun !== 2'b00) begin
            errors++;
            $display("FAIL rstmid got d%b v%b o%b want 11 00 00",
                     done, ref_valid, overrun);
        end
        for (int i = 0; i < 4; i++) begin
            set_rd(0, 1, i * 20);
            set_rd(1, 0, 64 - i);
            #1;
            checks++;
            if (ind_user !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_ind got %b want 00", ind_user);
            end
        end
        idle();
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        n = 0;
        while (m_tmr != RET - 1 && n < 400) begin
            cyc();
            n++;
        end
        start = 1;
        #1; cyc();
        start = 0;
        #1;
        checks++;
        if (ref_valid !== 2'b11 || oaddr(0) != 0 || overrun !== 2'b00) begin
            errors++;
            $display("FAIL tc_start got v%b a%0d o%b want 11 0 00",
                     ref_valid, oaddr(0), overrun);
        end
        cyc();
        w = 2;
        while (w <= 400) begin
            #1;
            if (w > 200 && ref_valid[0]) break;
            cyc();
            w++;
        end
        checks++;
        if (w != 301 || overrun !== 2'b00) begin
            errors++;
            $display("FAIL tc_period got w%0d o%b want 301 00",
                     w, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_read_prio();
        test_writes();
        test_stall();
        test_noskip();
        test_overrun();
        test_random();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
